// File: rtl/digit_serial_addsub_if.sv
// digit_serial_addsub_if: operand/result handshake bundle for the digit-serial adder
interface digit_serial_addsub_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             valid_out;
  logic [WIDTH:0]   result;
  logic             overflow;
  modport master (output start, sub, a, b, input ready, valid_out, result, overflow);
  modport slave  (input start, sub, a, b, output ready, valid_out, result, overflow);
endinterface

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: WIDTH-bit add/subtract computed DIGIT bits per clock
module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_addsub_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH:0]     res_q, res_d;
  logic               sub_q, sub_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DIGIT-1:0]   bx;
  logic [DIGIT:0]     dsum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic               cin_msb;
  assign bus.ready     = (state_q == IDLE);
  assign bus.valid_out = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.overflow  = ovf_q;
  // one digit of the ripple sum; the carry into the top bit is recovered as sum ^ a ^ b
  always_comb begin
    bx      = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};
    dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, bx} + {{DIGIT{1'b0}}, carry_q};
    cat     = {dsum[DIGIT-1:0], acc_q};
    cin_msb = a_q[DIGIT-1] ^ bx[DIGIT-1] ^ dsum[DIGIT-1];
  end
  // next-state and datapath updates; result/overflow only move on entry to DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = BUSY;
        a_d     = bus.a;
        b_d     = bus.b;
        sub_d   = bus.sub;
        carry_d = bus.sub;
        cnt_d   = '0;
      end
      BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          res_d   = {dsum[DIGIT] ^ sub_q, cat[WIDTH+DIGIT-1:DIGIT]};
          ovf_d   = cin_msb ^ dsum[DIGIT];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset clearing all state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: directed and random checks of three digit-serial configurations
module tb_digit_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  int   cfg = 0;
  int   cc = 0;
  int   wid [3] = '{8, 16, 8};
  int   nn  [3] = '{4, 4, 1};
  always #5 clk = ~clk;
  always @(posedge clk) cc <= cc + 1;
  digit_serial_addsub_if #(.WIDTH(8))  i0 ();
  digit_serial_addsub_if #(.WIDTH(16)) i1 ();
  digit_serial_addsub_if #(.WIDTH(8))  i2 ();
  digit_serial_addsub #(.WIDTH(8),  .DIGIT(2)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  digit_serial_addsub #(.WIDTH(8),  .DIGIT(8)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  logic        rdy_m, vld_m, ovf_m;
  logic [16:0] res_m;
  assign rdy_m = cfg == 0 ? i0.ready     : cfg == 1 ? i1.ready     : i2.ready;
  assign vld_m = cfg == 0 ? i0.valid_out : cfg == 1 ? i1.valid_out : i2.valid_out;
  assign ovf_m = cfg == 0 ? i0.overflow  : cfg == 1 ? i1.overflow  : i2.overflow;
  assign res_m = cfg == 0 ? 17'(i0.result) : cfg == 1 ? i1.result : 17'(i2.result);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cfg=%0d observed=%0h expected=%0h", tag, cfg, obs, exp);
    end
  endtask

  task automatic setin(input logic st, input logic [63:0] a, input logic [63:0] b, input logic s);
    i0.start = (cfg == 0) & st; i0.a = 8'(a);  i0.b = 8'(b);  i0.sub = s;
    i1.start = (cfg == 1) & st; i1.a = 16'(a); i1.b = 16'(b); i1.sub = s;
    i2.start = (cfg == 2) & st; i2.a = 8'(a);  i2.b = 8'(b);  i2.sub = s;
  endtask

  // reference: plain arithmetic on the full values, borrow = a<b, signed overflow from signs
  task automatic model(input int w, input logic [63:0] ai, input logic [63:0] bi, input logic s,
                       output logic [63:0] r, output logic o);
    logic [63:0] m, a, b;
    logic sa, sb, sr;
    m = (64'd1 << w) - 64'd1;
    a = ai & m;
    b = bi & m;
    r = s ? (((a - b) & m) | (a < b ? (64'd1 << w) : 64'd0)) : a + b;
    sa = a[w-1];
    sb = b[w-1];
    sr = r[w-1];
    o = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
  endtask

  task automatic op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s,
                    input logic [63:0] er, input logic eo);
    int cyc;
    @(negedge clk);
    chk({tag, "_ready_idle"}, rdy_m, 1);
    setin(1'b1, a, b, s);
    @(posedge clk);
    #1 setin(1'b0, $urandom, $urandom, 1'($urandom));
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!vld_m && cyc < 20);
    chk({tag, "_latency"}, cyc, nn[cfg]);
    chk({tag, "_ready_busy"}, rdy_m, 0);
    chk({tag, "_result"}, res_m, er);
    chk({tag, "_overflow"}, ovf_m, eo);
    @(negedge clk);
    chk({tag, "_valid_drop"}, vld_m, 0);
    chk({tag, "_ready_back"}, rdy_m, 1);
    chk({tag, "_result_hold"}, res_m, er);
  endtask

  initial begin
    logic [63:0] ra, rb, er;
    logic rs, eo;
    logic [63:0] va [3] = '{1, 200, 50};
    logic [63:0] vb [3] = '{2, 100, 60};
    logic        vs [3] = '{0, 1, 0};
    logic [63:0] ve [3] = '{3, 100, 110};
    logic        vo [3] = '{0, 1, 0};
    int t [3];
    int cyc, seen;
    setin(1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      cfg = c;
      #0;
      chk("reset_ready", rdy_m, 1);
      chk("reset_valid", vld_m, 0);
      chk("reset_result", res_m, 0);
      chk("reset_overflow", ovf_m, 0);
    end
    rst_n = 1'b1;
    cfg = 0;
    op("add_10_15", 10, 15, 0, 25, 0);
    op("add_255_255", 255, 255, 0, 9'h1FE, 0);
    op("add_127_120", 127, 120, 0, 247, 1);
    op("add_100_55", 100, 55, 0, 155, 1);
    op("sub_100_55", 100, 55, 1, 45, 0);
    op("sub_15_16", 15, 16, 1, 9'h1FF, 0);
    op("sub_80_1", 8'h80, 1, 1, 9'h07F, 1);
    // start held high, operands scrambled while busy: each op uses only its accepted operands
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc = 0;
      while (!rdy_m && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      setin(1'b1, va[i], vb[i], vs[i]);
      @(posedge clk);
      #1 setin(1'b1, $urandom, $urandom, 1'($urandom));
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!vld_m && cyc < 20);
      t[i] = cc;
      chk("b2b_valid_seen", vld_m, 1);
      chk("b2b_result", res_m, ve[i]);
      chk("b2b_overflow", ovf_m, vo[i]);
    end
    setin(1'b0, 0, 0, 1'b0);
    chk("b2b_spacing_1", t[1] - t[0], 6);
    chk("b2b_spacing_2", t[2] - t[1], 6);
    // reset during the second busy cycle aborts the op
    @(negedge clk);
    @(negedge clk);
    setin(1'b1, 100, 55, 1'b0);
    @(posedge clk);
    #1 setin(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", rdy_m, 1);
    chk("rst_mid_valid", vld_m, 0);
    chk("rst_mid_result", res_m, 0);
    chk("rst_mid_overflow", ovf_m, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(vld_m);
    end
    chk("rst_mid_no_valid", seen, 0);
    op("post_rst_add", 10, 15, 0, 25, 0);
    cfg = 1;
    op("w16_ffff_plus_1", 16'hFFFF, 1, 0, 17'h10000, 0);
    cfg = 2;
    op("w8d8_add", 10, 15, 0, 25, 0);
    for (int c = 0; c < 3; c++) begin
      cfg = c;
      for (int k = 0; k < 1000; k++) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom);
        model(wid[c], ra, rb, rs, er, eo);
        op("random", ra, rb, rs, er, eo);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
